// File: rtl/pool_pingpong_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : pool_pingpong_scheduler
// Purpose : Ping-pong (double-buffer) scheduler between the pooling stage's
//           output writes and the next convolution stage's reads. The
//           producer fills one IFM bank while the consumer reads the other.
//           The block generates write addresses and bank selects, holds off
//           the producer when no bank is free, and issues one start pulse
//           per completed frame.
// Ports   :
//   clk                    in   rising-edge clock
//   reset                  in   synchronous, active-high reset
//   wr_valid               in   producer writes one word this cycle
//   end_from_next          in   pulse: consumer finished the current frame
//   ifm_address_write_next out  word address for the current write
//   wr_bank_sel            out  bank receiving writes
//   prod_hold              out  producer must not assert wr_valid
//   start_to_next          out  pulse: frame ready for the consumer
//   rd_bank_sel            out  bank the consumer reads
//   ifm_sel_next           out  group index of the frame being read
//   full_banks             out  number of banks in FULL or READING (0..2)
//   protocol_err           out  sticky protocol error flag
// Revision: 1.0 - initial release
// ============================================================================
module pool_pingpong_scheduler #(
  parameter int IFM_SIZE_NEXT         = 7,
  parameter int NUMBER_OF_IFM_NEXT    = 6,
  parameter int NUMBER_OF_UNITS       = 3,
  parameter int FRAME_WORDS           = IFM_SIZE_NEXT * IFM_SIZE_NEXT,
  parameter int NUM_GROUPS            = NUMBER_OF_IFM_NEXT / NUMBER_OF_UNITS,
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(FRAME_WORDS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_valid,
  input  logic                               end_from_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0]   ifm_address_write_next,
  output logic                               wr_bank_sel,
  output logic                               prod_hold,
  output logic                               start_to_next,
  output logic                               rd_bank_sel,
  output logic [$clog2(NUM_GROUPS+1)-1:0]    ifm_sel_next,
  output logic [1:0]                         full_banks,
  output logic                               protocol_err
);

  localparam int GROUP_W = $clog2(NUM_GROUPS + 1);
  localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] LAST_ADDR =
    ADDRESS_SIZE_NEXT_IFM'(FRAME_WORDS - 1);
  localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  bank_state_t                      bank_q [2];
  bank_state_t                      bank_d [2];
  logic                             wr_ptr_q, wr_ptr_d;
  logic                             rd_ptr_q, rd_ptr_d;
  logic                             busy_q, busy_d;
  logic [GROUP_W-1:0]               rd_group_q, rd_group_d;
  logic [GROUP_W-1:0]               sel_q, sel_d;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] addr_q, addr_d;
  logic                             start_q, start_d;
  logic                             err_q, err_d;
  logic [1:0]                       full_q, full_d;
  logic                             hold;
  logic                             wr_accept;

  // A bank counts as occupied once it holds a complete frame, until freed.
  function automatic logic occupied(input bank_state_t s);
    return (s == FULL) || (s == READING);
  endfunction

  // Hold depends only on registered state, so there is no input-to-output path.
  assign hold      = occupied(bank_q[wr_ptr_q]);
  assign wr_accept = wr_valid && !hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]  <= FREE;
      bank_q[1]  <= FREE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      busy_q     <= 1'b0;
      rd_group_q <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      full_q     <= 2'd0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
      rd_group_q <= rd_group_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      start_q    <= start_d;
      err_q      <= err_d;
      full_q     <= full_d;
    end
  end

  always_comb begin
    bank_d[0]  = bank_q[0];
    bank_d[1]  = bank_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    busy_d     = busy_q;
    rd_group_d = rd_group_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    start_d    = 1'b0;
    err_d      = err_q;

    // Producer side: a write into an occupied bank is dropped and flagged.
    if (wr_valid && hold) begin
      err_d = 1'b1;
    end
    if (wr_accept) begin
      if (addr_q == LAST_ADDR) begin
        bank_d[wr_ptr_q] = FULL;
        addr_d           = '0;
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        bank_d[wr_ptr_q] = FILLING;
        addr_d           = addr_q + 1'b1;
      end
    end

    // Consumer release. A write can never target the READING bank (it is
    // held), so a coincident last-word write always lands on the other bank.
    if (end_from_next) begin
      if (busy_q) begin
        bank_d[rd_ptr_q] = FREE;
        rd_ptr_d         = ~rd_ptr_q;
        busy_d           = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    // Issue is exclusive with a valid release (busy differs), and the issued
    // bank is FULL so no write can touch it in the same cycle.
    if ((bank_q[rd_ptr_q] == FULL) && !busy_q) begin
      start_d          = 1'b1;
      bank_d[rd_ptr_q] = READING;
      busy_d           = 1'b1;
      sel_d            = rd_group_q;
      rd_group_d       = (rd_group_q == LAST_GROUP) ? '0 : rd_group_q + 1'b1;
    end

    full_d = {1'b0, occupied(bank_d[0])} + {1'b0, occupied(bank_d[1])};
  end

  assign ifm_address_write_next = addr_q;
  assign wr_bank_sel            = wr_ptr_q;
  assign prod_hold              = hold;
  assign start_to_next          = start_q;
  assign rd_bank_sel            = rd_ptr_q;
  assign ifm_sel_next           = sel_q;
  assign full_banks             = full_q;
  assign protocol_err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_pingpong_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_pool_pingpong_scheduler
// Purpose : Self-checking bench for pool_pingpong_scheduler. Stimulus pushes
//           expected write addresses and start events into queues; a monitor
//           pops and compares whenever the DUT accepts a write or pulses
//           start_to_next.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pool_pingpong_scheduler;

  localparam int FW = 49;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       end_from_next = 1'b0;
  logic [5:0] ifm_address_write_next;
  logic       wr_bank_sel;
  logic       prod_hold;
  logic       start_to_next;
  logic       rd_bank_sel;
  logic [1:0] ifm_sel_next;
  logic [1:0] full_banks;
  logic       protocol_err;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int addr; int bank;} wr_exp_t;
  typedef struct {int bank; int sel; int cyc;} st_exp_t;
  wr_exp_t wr_q[$];
  st_exp_t st_q[$];

  pool_pingpong_scheduler dut (
    .clk                    (clk),
    .reset                  (reset),
    .wr_valid               (wr_valid),
    .end_from_next          (end_from_next),
    .ifm_address_write_next (ifm_address_write_next),
    .wr_bank_sel            (wr_bank_sel),
    .prod_hold              (prod_hold),
    .start_to_next          (start_to_next),
    .rd_bank_sel            (rd_bank_sel),
    .ifm_sel_next           (ifm_sel_next),
    .full_banks             (full_banks),
    .protocol_err           (protocol_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  int'(ifm_address_write_next), 0);
    check({tag, "_wrsel"}, int'(wr_bank_sel), 0);
    check({tag, "_hold"},  int'(prod_hold), 0);
    check({tag, "_start"}, int'(start_to_next), 0);
    check({tag, "_rdsel"}, int'(rd_bank_sel), 0);
    check({tag, "_ifmsel"}, int'(ifm_sel_next), 0);
    check({tag, "_full"},  int'(full_banks), 0);
    check({tag, "_err"},   int'(protocol_err), 0);
  endtask

  // Drive n consecutive writes whose addresses start at 'first'.
  task automatic write_words(input int first, input int n, input int bank);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_q.push_back('{first + i, bank});
      tick();
    end
    wr_valid = 1'b0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_valid && !prod_hold) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          check("wr_addr", int'(ifm_address_write_next), w.addr);
          check("wr_bank", int'(wr_bank_sel), w.bank);
        end
      end
      if (start_to_next) begin
        if (st_q.size() == 0) begin
          check("start_unexpected", 1, 0);
        end else begin
          st_exp_t s;
          s = st_q.pop_front();
          check("start_cycle", cyc, s.cyc);
          check("start_rdsel", int'(rd_bank_sel), s.bank);
          check("start_ifmsel", int'(ifm_sel_next), s.sel);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // First frame into bank 0; start two cycles after the last word.
    st_q.push_back('{0, 0, cyc + FW + 1});
    write_words(0, FW, 0);
    check("f1_wrsel", int'(wr_bank_sel), 1);
    check("f1_full", int'(full_banks), 1);
    check("f1_hold", int'(prod_hold), 0);

    // Second frame into bank 1, consumer never finishes: both banks occupied.
    write_words(0, FW, 1);
    check("f2_hold", int'(prod_hold), 1);
    check("f2_full", int'(full_banks), 2);
    check("f2_wrsel", int'(wr_bank_sel), 0);
    check("f2_addr", int'(ifm_address_write_next), 0);

    // Write while held: dropped and flagged.
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("drop_err", int'(protocol_err), 1);
    check("drop_addr", int'(ifm_address_write_next), 0);
    check("drop_hold", int'(prod_hold), 1);

    // Consumer finishes bank 0; bank 1 issues at e+2 with group 1.
    st_q.push_back('{1, 1, cyc + 2});
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    check("rel_hold", int'(prod_hold), 0);
    check("rel_full", int'(full_banks), 1);
    check("rel_rdsel", int'(rd_bank_sel), 1);
    check("rel_start", int'(start_to_next), 0);
    tick();
    check("iss2_start", int'(start_to_next), 1);

    // Third frame into bank 0, last word coincident with end_from_next.
    st_q.push_back('{0, 0, cyc + FW + 1});
    write_words(0, FW - 1, 0);
    wr_valid = 1'b1;
    end_from_next = 1'b1;
    wr_q.push_back('{FW - 1, 0});
    tick();
    wr_valid = 1'b0;
    end_from_next = 1'b0;
    check("co_full", int'(full_banks), 1);
    check("co_hold", int'(prod_hold), 0);
    check("co_wrsel", int'(wr_bank_sel), 1);
    check("co_rdsel", int'(rd_bank_sel), 0);
    check("co_start", int'(start_to_next), 0);
    tick();
    check("wrap_start", int'(start_to_next), 1);
    check("wrap_full", int'(full_banks), 1);
    tick();
    check("wrap_ifmsel_stable", int'(ifm_sel_next), 0);

    // Stray end_from_next with nothing being read.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    check("stray_err", int'(protocol_err), 1);
    check("stray_rdsel", int'(rd_bank_sel), 0);
    check("stray_wrsel", int'(wr_bank_sel), 0);
    check("stray_full", int'(full_banks), 0);
    check("stray_hold", int'(prod_hold), 0);

    // Reset in mid-frame discards the partial frame.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    write_words(0, 20, 0);
    check("mid_addr", int'(ifm_address_write_next), 20);
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    reset = 1'b0;
    st_q.push_back('{0, 0, cyc + FW + 1});
    write_words(0, FW, 0);
    tick();
    tick();
    check("post_wrsel", int'(wr_bank_sel), 1);
    check("post_full", int'(full_banks), 1);
    check("post_err", int'(protocol_err), 0);

    repeat (4) tick();
    check("wr_left", wr_q.size(), 0);
    check("start_missing", st_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
